max_search_ctrl: RTL and testbench
==================================

Name: max_search_ctrl

Overview:
- Sequential controller that reuses the combinational `two_bit_greater` comparator to find the maximum of a frame of N_SAMPLES 2-bit values.
- Values arrive one per handshake.
- Tracks the running maximum and the position where it first occurred, then reports both with a done pulse.
- Sits between a sample source (switches/stream producer) and a display/result consumer.

Parameters:
- N_SAMPLES, 8, number of samples per frame; legal range 1..2**IDX_W
- IDX_W, 3, width of the sample counter and index output; must satisfy 2**IDX_W >= N_SAMPLES

Ports:
- clk  input  1  system clock; all logic on the rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request to begin a new frame; sampled only in IDLE
- in_valid  input  1  producer has a sample on in_data
- in_data  input  2  sample value, unsigned
- in_ready  output  1  controller accepts a sample this cycle
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse when the result is final
- result_valid  output  1  high from the done cycle until the next accepted start
- max_val  output  2  maximum value of the last completed frame
- max_idx  output  IDX_W  index (0-based) of the first sample equal to max_val

Behaviour:
- Clock and reset:
  - One clock, clk.
  - reset is synchronous and active-high, taking effect only on a rising edge of clk.
- Reset values:
  - State IDLE.
  - in_ready=0, busy=0, done=0, result_valid=0.
  - max_val=0, max_idx=0, counter=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=0.
  - On start=1: clear counter and the running max/index registers, drop result_valid, go to RUN.
  - in_valid is ignored in IDLE.
- RUN:
  - in_ready=1.
  - A transfer occurs in a cycle with in_valid=1 and in_ready=1.
  - On a transfer with counter==0: load running max=in_data, running index=0, unconditionally.
  - On a transfer with counter>0:
    - The comparator evaluates a=in_data, b=running max.
    - If agreaterb=1, load running max=in_data and running index=counter.
    - Otherwise hold.
  - Strictly-greater compare means ties keep the earliest index.
  - Counter increments on each transfer.
  - On the transfer with counter==N_SAMPLES-1, go to DONE.
  - in_ready drops in DONE, so no extra sample is accepted.
  - in_valid=0 stalls without limit; no timeout.
- DONE (exactly one cycle):
  - done=1.
  - Copy running max/index to max_val/max_idx, which are valid in the same cycle as done.
  - Set result_valid=1, return to IDLE.
- Latency: done is asserted in the cycle after the last accepted sample.
  - Minimum frame time is N_SAMPLES+2 cycles from start: 1 IDLE→RUN, N transfers, 1 DONE.
- Output holding:
  - max_val/max_idx hold the last completed result through IDLE.
  - They are not disturbed by a frame in progress; running registers are internal.
  - They update only in DONE.
- start:
  - start while busy is ignored, with no queuing.
  - start asserted in the DONE cycle is ignored.
  - start must be seen in IDLE.
- N_SAMPLES=1: the first transfer goes straight to DONE; max_idx=0.
- Reset mid-frame: returns to IDLE on that edge and discards the partial frame; outputs take reset values (result_valid=0).
- Counter width: IDX_W bits.
  - Counter never exceeds N_SAMPLES-1, so there is no wrap within a frame.

Decomposition:
- Shared package `cmp_pkg`:
  - FSM state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10).
  - Sample width constant DATA_W=2.
- Sub-module: one instance of the existing `two_bit_greater` as the compare datapath.
- All sequencing stays in max_search_ctrl.

Test Plan:
- Reset then idle: assert reset for 2 cycles, then start=0, in_valid=1 for 5 cycles.
  - Expect in_ready=0, busy=0, done=0, result_valid=0, max_val=0, max_idx=0 throughout.
- Basic frame (N=8): start, then stream 1,0,2,1,3,0,2,1 with in_valid held high.
  - Expect done pulse exactly 1 cycle after the 8th transfer, with max_val=3, max_idx=4, result_valid=1.
  - busy returns low the next cycle.
- Tie and stall: stream 2,1,2,0,2,1,0,0 with in_valid=0 gaps of 3 cycles after samples 2 and 5.
  - Expect max_val=2, max_idx=0 (first occurrence).
  - Expect in_ready=1 during gaps and no counter advance.
- All equal/minimum: stream eight 0s.
  - Expect max_val=0, max_idx=0.
  - Then a second frame 0,0,0,0,0,0,0,3.
  - Expect max_idx=7, and the previous result held until its done.
- Start while busy: pulse start during sample 3 of a frame and in the DONE cycle.
  - Expect the frame to complete unaffected and the controller to return to IDLE, not RUN.
- Reset mid-frame: assert reset after 4 transfers.
  - Expect IDLE with result_valid=0 on the next edge.
  - A subsequent full frame 3,3,0,0,0,0,0,1 gives max_val=3, max_idx=0.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared types and constants for the max-search controller and its comparator.
package cmp_pkg;

   // Width of one sample value.
   localparam int DATA_W = 2;

   // Controller sequencing states.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage

// File: rtl/two_bit_greater.sv
// Combinational magnitude comparator: agreaterb is high when a > b (unsigned).
module two_bit_greater (
   input  logic [1:0] a,
   input  logic [1:0] b,
   output logic       agreaterb
);

   // a wins on the MSB alone, or on the LSB when the MSBs are equal.
   assign agreaterb = (a[1] & ~b[1]) | ((a[1] ~^ b[1]) & a[0] & ~b[0]);

endmodule

// File: rtl/max_search_ctrl.sv
// Finds the maximum of a frame of N_SAMPLES values and the index of its
// first occurrence, then reports both with a one-cycle done pulse.
module max_search_ctrl
   import cmp_pkg::*;
#(
   parameter int N_SAMPLES = 8,
   parameter int IDX_W     = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              busy,
   output logic              done,
   output logic              result_valid,
   output logic [DATA_W-1:0] max_val,
   output logic [IDX_W-1:0]  max_idx
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SAMPLES - 1);

   state_t             state_reg;
   state_t             state_next;
   logic [IDX_W-1:0]   counter_reg;
   logic [DATA_W-1:0]  run_max_reg;
   logic [IDX_W-1:0]   run_idx_reg;
   logic [DATA_W-1:0]  max_val_reg;
   logic [IDX_W-1:0]   max_idx_reg;
   logic               result_valid_reg;
   logic               agreaterb;
   logic               xfer;
   logic               last_xfer;

   // Compare the incoming sample against the running maximum.
   two_bit_greater u_cmp (
      .a         (in_data),
      .b         (run_max_reg),
      .agreaterb (agreaterb)
   );

   assign xfer      = (state_reg == RUN) && in_valid;
   assign last_xfer = xfer && (counter_reg == LAST_IDX);

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state and handshake/status outputs. The result is presented
   // straight from the running registers during DONE so it lines up with done.
   always_comb begin
      state_next   = state_reg;
      in_ready     = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      result_valid = result_valid_reg;
      max_val      = max_val_reg;
      max_idx      = max_idx_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = RUN;
            end
         end
         RUN: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (last_xfer) begin
               state_next = DONE;
            end
         end
         DONE: begin
            busy         = 1'b1;
            done         = 1'b1;
            result_valid = 1'b1;
            max_val      = run_max_reg;
            max_idx      = run_idx_reg;
            state_next   = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath: running max/index tracking and the held result registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         counter_reg      <= '0;
         run_max_reg      <= '0;
         run_idx_reg      <= '0;
         max_val_reg      <= '0;
         max_idx_reg      <= '0;
         result_valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  counter_reg      <= '0;
                  run_max_reg      <= '0;
                  run_idx_reg      <= '0;
                  result_valid_reg <= 1'b0;
               end
            end
            RUN: begin
               if (xfer) begin
                  // First sample loads unconditionally; later ones only on a
                  // strict win, so ties keep the earliest index.
                  if (counter_reg == '0 || agreaterb) begin
                     run_max_reg <= in_data;
                     run_idx_reg <= counter_reg;
                  end
                  counter_reg <= last_xfer ? '0 : counter_reg + 1'b1;
               end
            end
            DONE: begin
               max_val_reg      <= run_max_reg;
               max_idx_reg      <= run_idx_reg;
               result_valid_reg <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_max_search_ctrl.sv
// Self-checking bench for max_search_ctrl: a frame-level reference model
// checked every cycle, plus hand-computed expectations per frame.
module tb_max_search_ctrl;

   localparam int N = 8;
   localparam int P_IDLE = 0;
   localparam int P_RUN  = 1;
   localparam int P_DONE = 2;

   logic       clk;
   logic       reset;
   logic       start;
   logic       in_valid;
   logic [1:0] in_data;
   logic       in_ready;
   logic       busy;
   logic       done;
   logic       result_valid;
   logic [1:0] max_val;
   logic [2:0] max_idx;

   int n_checks = 0;
   int n_fail   = 0;

   max_search_ctrl #(.N_SAMPLES(N), .IDX_W(3)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .busy         (busy),
      .done         (done),
      .result_valid (result_valid),
      .max_val      (max_val),
      .max_idx      (max_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: tracks the frame by observed handshakes and derives
   // the result from the collected samples once the frame is complete.
   int         ph = P_IDLE;
   int         cnt = 0;
   int         exp_rv = 0;
   int         exp_max = 0;
   int         exp_idx = 0;
   bit         chk_en = 1'b0;
   int         frame[N];

   always @(negedge clk) begin
      if (chk_en) begin
         chk("in_ready", int'(in_ready), int'(ph == P_RUN));
         chk("busy", int'(busy), int'(ph != P_IDLE));
         chk("done", int'(done), int'(ph == P_DONE));
         chk("result_valid", int'(result_valid), exp_rv);
         chk("max_val", int'(max_val), exp_max);
         chk("max_idx", int'(max_idx), exp_idx);
      end
      if (reset) begin
         ph = P_IDLE; cnt = 0; exp_rv = 0; exp_max = 0; exp_idx = 0;
         chk_en = 1'b1;
      end else if (chk_en) begin
         case (ph)
            P_IDLE: if (start) begin ph = P_RUN; cnt = 0; exp_rv = 0; end
            P_RUN: if (in_valid) begin
               frame[cnt] = int'(in_data);
               cnt++;
               if (cnt == N) begin
                  exp_max = -1;
                  for (int i = 0; i < N; i++) begin
                     if (frame[i] > exp_max) begin
                        exp_max = frame[i];
                        exp_idx = i;
                     end
                  end
                  exp_rv = 1;
                  ph = P_DONE;
               end
            end
            default: ph = P_IDLE;
         endcase
      end
   end

   // Wait for the done pulse (bounded) and check the literal result.
   task automatic wait_done(input string tag, input int ev, input int ei);
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!done && k < 20);
      chk({tag, " done latency"}, k, 1);
      chk({tag, " max_val"}, int'(max_val), ev);
      chk({tag, " max_idx"}, int'(max_idx), ei);
      chk({tag, " result_valid"}, int'(result_valid), 1);
      $display("frame %s: max_val=%0d max_idx=%0d done_after=%0d", tag, max_val, max_idx, k);
   endtask

   task automatic run_frame(input string tag, input int s[N], input int gaps[N],
                            input bit start_mid, input bit start_done,
                            input int ev, input int ei);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < N; i++) begin
         in_valid = 1'b1;
         in_data  = 2'(s[i]);
         start    = start_mid && (i == 2);
         @(posedge clk); #1;
         start = 1'b0;
         if (gaps[i] > 0) begin
            in_valid = 1'b0;
            repeat (gaps[i]) @(posedge clk);
            #1;
         end
      end
      in_valid = 1'b0;
      start    = start_done;
      wait_done(tag, ev, ei);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   int s[N];
   int g[N];
   int nog[N];

   initial begin
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 2'd0;
      nog = '{0, 0, 0, 0, 0, 0, 0, 0};
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      in_valid = 1'b1; in_data = 2'd3;
      repeat (5) @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("idle busy", int'(busy), 0);
      chk("idle result_valid", int'(result_valid), 0);
      chk("idle max_val", int'(max_val), 0);
      $display("reset/idle: in_ready=%0d busy=%0d result_valid=%0d", in_ready, busy, result_valid);

      s = '{1, 0, 2, 1, 3, 0, 2, 1};
      run_frame("basic", s, nog, 1'b0, 1'b0, 3, 4);
      chk("basic busy after", int'(busy), 0);

      s = '{2, 1, 2, 0, 2, 1, 0, 0};
      g = '{0, 3, 0, 0, 3, 0, 0, 0};
      run_frame("tie_stall", s, g, 1'b0, 1'b0, 2, 0);

      s = '{0, 0, 0, 0, 0, 0, 0, 0};
      run_frame("zeros", s, nog, 1'b0, 1'b0, 0, 0);
      s = '{0, 0, 0, 0, 0, 0, 0, 3};
      run_frame("last_max", s, nog, 1'b0, 1'b0, 3, 7);

      s = '{1, 2, 3, 2, 1, 0, 3, 0};
      run_frame("start_busy", s, nog, 1'b1, 1'b1, 3, 2);
      @(posedge clk); #1;
      chk("start_busy idle in_ready", int'(in_ready), 0);
      chk("start_busy idle busy", int'(busy), 0);

      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_data = 2'd3;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("midrst result_valid", int'(result_valid), 0);
      chk("midrst busy", int'(busy), 0);
      chk("midrst max_val", int'(max_val), 0);
      $display("reset mid-frame: busy=%0d result_valid=%0d", busy, result_valid);

      s = '{3, 3, 0, 0, 0, 0, 0, 1};
      run_frame("after_rst", s, nog, 1'b0, 1'b0, 3, 0);

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
